// File: rtl/right_flipper_ctrl.sv
// -----------------------------------------------------------------------------
// right_flipper_ctrl
//
// Sequences the right flipper swing. The button level, sampled once per video
// frame, drives a four-state FSM (REST / RISING / HOLD / FALLING) that walks an
// 8-entry angle table. The table index is converted into the moving-edge
// coordinates (X1, Y1) used by the flipper draw block. Ball physics receives a
// "flipper up" flag and a one-clock kick pulse when the flipper reaches the top.
//
// Parameters:
//   XC, YC       pivot coordinates (must match the draw block's fixed edge)
//   STEP_FRAMES  frames per angle step, 1..15
//
// Ports:
//   clk            system clock
//   resetN         asynchronous active-low reset
//   startOfFrame   one-clock pulse per frame; the only event that advances the FSM
//   buttonPress    flipper key level, sampled only on startOfFrame
//   X1, Y1         signed tip coordinates: X1 = XC - DX[idx], Y1 = YC + DY[idx]
//   angleIdx       current angle table index (0 = rest, 7 = fully raised)
//   flipperUp      high while RISING or HOLD
//   flipperMoving  high while RISING or FALLING
//   kickPulse      one-clock pulse on the frame where idx reaches 7 while rising
// -----------------------------------------------------------------------------
module right_flipper_ctrl #(
    parameter int XC          = 455,
    parameter int YC          = 400,
    parameter int STEP_FRAMES = 2
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               buttonPress,
    output logic signed [10:0] X1,
    output logic signed [10:0] Y1,
    output logic        [2:0]  angleIdx,
    output logic               flipperUp,
    output logic               flipperMoving,
    output logic               kickPulse
);

    typedef enum logic [1:0] {
        REST    = 2'd0,
        RISING  = 2'd1,
        HOLD    = 2'd2,
        FALLING = 2'd3
    } state_t;

    localparam logic signed [10:0] XC_S      = 11'(XC);
    localparam logic signed [10:0] YC_S      = 11'(YC);
    localparam logic        [3:0]  LAST_FRAME = 4'(STEP_FRAMES - 1);
    localparam logic        [2:0]  IDX_TOP    = 3'd7;
    localparam logic        [2:0]  IDX_BOTTOM = 3'd0;

    state_t              r_state;
    logic        [2:0]   r_idx;
    logic        [3:0]   r_frame_cnt;
    logic signed [10:0]  r_x1;
    logic signed [10:0]  r_y1;
    logic                r_kick;
    // Clears on reset, sets on the first clock afterwards: a frame pulse that
    // coincides with reset release is not acted on.
    logic                r_armed;

    state_t              w_state_next;
    logic        [2:0]   w_idx_next;
    logic        [3:0]   w_frame_cnt_next;
    logic                w_kick_next;
    logic                w_frame_evt;
    logic        [2:0]   w_idx_up;
    logic        [2:0]   w_idx_down;
    logic signed [10:0]  w_dx;
    logic signed [10:0]  w_dy;

    assign w_frame_evt = startOfFrame & r_armed;

    // Saturating neighbours of the current index.
    assign w_idx_up   = (r_idx == IDX_TOP)    ? IDX_TOP    : r_idx + 3'd1;
    assign w_idx_down = (r_idx == IDX_BOTTOM) ? IDX_BOTTOM : r_idx - 3'd1;

    // Next-state logic; only consumed on a frame event.
    always_comb begin
        w_state_next     = r_state;
        w_idx_next       = r_idx;
        w_frame_cnt_next = r_frame_cnt;
        w_kick_next      = 1'b0;
        unique case (r_state)
            REST: begin
                if (buttonPress) begin
                    w_state_next     = RISING;
                    w_frame_cnt_next = 4'd0;
                end
            end
            RISING: begin
                if (!buttonPress) begin
                    // Reversal keeps the angle; the frame count restarts.
                    w_state_next     = FALLING;
                    w_frame_cnt_next = 4'd0;
                end else if (r_frame_cnt == LAST_FRAME) begin
                    w_idx_next       = w_idx_up;
                    w_frame_cnt_next = 4'd0;
                    if (w_idx_up == IDX_TOP) begin
                        w_state_next = HOLD;
                        w_kick_next  = 1'b1;
                    end
                end else begin
                    w_frame_cnt_next = r_frame_cnt + 4'd1;
                end
            end
            HOLD: begin
                if (!buttonPress) begin
                    w_state_next     = FALLING;
                    w_frame_cnt_next = 4'd0;
                end
            end
            FALLING: begin
                if (buttonPress) begin
                    w_state_next     = RISING;
                    w_frame_cnt_next = 4'd0;
                end else if (r_frame_cnt == LAST_FRAME) begin
                    w_idx_next       = w_idx_down;
                    w_frame_cnt_next = 4'd0;
                    if (w_idx_down == IDX_BOTTOM) begin
                        w_state_next = REST;
                    end
                end else begin
                    w_frame_cnt_next = r_frame_cnt + 4'd1;
                end
            end
            default: begin
                w_state_next     = REST;
                w_idx_next       = IDX_BOTTOM;
                w_frame_cnt_next = 4'd0;
            end
        endcase
    end

    // Angle table lookup for the index about to be loaded, so the coordinate
    // registers update on the same edge as the index.
    always_comb begin
        w_dx = 11'sd52;
        w_dy = 11'sd30;
        unique case (w_idx_next)
            3'd0: begin w_dx = 11'sd52; w_dy =  11'sd30; end
            3'd1: begin w_dx = 11'sd56; w_dy =  11'sd22; end
            3'd2: begin w_dx = 11'sd58; w_dy =  11'sd13; end
            3'd3: begin w_dx = 11'sd60; w_dy =  11'sd4;  end
            3'd4: begin w_dx = 11'sd60; w_dy = -11'sd4;  end
            3'd5: begin w_dx = 11'sd58; w_dy = -11'sd13; end
            3'd6: begin w_dx = 11'sd56; w_dy = -11'sd22; end
            3'd7: begin w_dx = 11'sd52; w_dy = -11'sd30; end
            default: begin w_dx = 11'sd52; w_dy = 11'sd30; end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= REST;
            r_idx       <= IDX_BOTTOM;
            r_frame_cnt <= 4'd0;
            r_x1        <= XC_S - 11'sd52;
            r_y1        <= YC_S + 11'sd30;
            r_kick      <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            // The kick is a single-clock pulse: it drops on every non-setting edge.
            r_kick  <= w_frame_evt & w_kick_next;
            if (w_frame_evt) begin
                r_state     <= w_state_next;
                r_idx       <= w_idx_next;
                r_frame_cnt <= w_frame_cnt_next;
                r_x1        <= XC_S - w_dx;
                r_y1        <= YC_S + w_dy;
            end
        end
    end

    assign X1            = r_x1;
    assign Y1            = r_y1;
    assign angleIdx      = r_idx;
    assign kickPulse     = r_kick;
    assign flipperUp     = (r_state == RISING) || (r_state == HOLD);
    assign flipperMoving = (r_state == RISING) || (r_state == FALLING);

endmodule

// File: tb/tb_right_flipper_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for right_flipper_ctrl. Two instances share the stimulus: one with
// STEP_FRAMES=2, one with STEP_FRAMES=1. A behavioural model (direction +
// frames-remaining per instance) predicts every output and is compared on each
// falling clock edge; directed literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_right_flipper_ctrl;

    logic clk = 1'b0;
    logic resetN;
    logic startOfFrame;
    logic buttonPress;

    logic signed [10:0] x1_o   [2];
    logic signed [10:0] y1_o   [2];
    logic        [2:0]  idx_o  [2];
    logic               up_o   [2];
    logic               mov_o  [2];
    logic               kick_o [2];

    always #5 clk = ~clk;

    right_flipper_ctrl #(.XC(455), .YC(400), .STEP_FRAMES(2)) dut0 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .buttonPress(buttonPress),
        .X1(x1_o[0]), .Y1(y1_o[0]), .angleIdx(idx_o[0]), .flipperUp(up_o[0]),
        .flipperMoving(mov_o[0]), .kickPulse(kick_o[0])
    );

    right_flipper_ctrl #(.XC(455), .YC(400), .STEP_FRAMES(1)) dut1 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .buttonPress(buttonPress),
        .X1(x1_o[1]), .Y1(y1_o[1]), .angleIdx(idx_o[1]), .flipperUp(up_o[1]),
        .flipperMoving(mov_o[1]), .kickPulse(kick_o[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int DX [8] = '{52, 56, 58, 60, 60, 58, 56, 52};
    int DY [8] = '{30, 22, 13, 4, -4, -13, -22, -30};
    int STEP [2] = '{2, 1};

    int m_idx  [2] = '{0, 0};
    int m_dir  [2] = '{0, 0};   // +1 swinging up, -1 swinging down, 0 parked
    int m_wait [2] = '{0, 0};   // frames left before the next angle step
    bit m_kick [2] = '{0, 0};
    bit m_live [2] = '{0, 0};   // false on the first clock after reset

    task automatic model_frame(input int k, input bit b);
        if (m_dir[k] == 0) begin
            if (m_idx[k] == 0 && b) begin
                m_dir[k] = 1;  m_wait[k] = STEP[k];
            end else if (m_idx[k] == 7 && !b) begin
                m_dir[k] = -1; m_wait[k] = STEP[k];
            end
        end else if ((m_dir[k] == 1) != b) begin
            m_dir[k]  = -m_dir[k];
            m_wait[k] = STEP[k];
        end else begin
            m_wait[k]--;
            if (m_wait[k] == 0) begin
                m_wait[k] = STEP[k];
                m_idx[k]  = m_idx[k] + m_dir[k];
                if (m_idx[k] < 0) m_idx[k] = 0;
                if (m_idx[k] == 7 && m_dir[k] == 1) begin
                    m_dir[k]  = 0;
                    m_kick[k] = 1'b1;
                end else if (m_idx[k] == 0 && m_dir[k] == -1) begin
                    m_dir[k] = 0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!resetN) begin
                m_idx[k] = 0; m_dir[k] = 0; m_wait[k] = 0;
                m_kick[k] = 1'b0; m_live[k] = 1'b0;
            end else begin
                m_kick[k] = 1'b0;
                if (startOfFrame && m_live[k]) model_frame(k, buttonPress);
                m_live[k] = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int e_idx, e_dir;
            bit e_kick;
            if (!resetN) begin
                e_idx = 0; e_dir = 0; e_kick = 1'b0;
            end else begin
                e_idx = m_idx[k]; e_dir = m_dir[k]; e_kick = m_kick[k];
            end
            chk($sformatf("cyc_idx_d%0d", k),  int'(idx_o[k]), e_idx);
            chk($sformatf("cyc_x1_d%0d", k),   int'(x1_o[k]), 455 - DX[e_idx]);
            chk($sformatf("cyc_y1_d%0d", k),   int'(y1_o[k]), 400 + DY[e_idx]);
            chk($sformatf("cyc_up_d%0d", k),   int'(up_o[k]),
                int'(e_dir == 1 || (e_dir == 0 && e_idx == 7)));
            chk($sformatf("cyc_mov_d%0d", k),  int'(mov_o[k]), int'(e_dir != 0));
            chk($sformatf("cyc_kick_d%0d", k), int'(kick_o[k]), int'(e_kick));
        end
    end

    // ---------------- stimulus ----------------
    // Idle two clocks, then a one-clock frame pulse; returns on the falling
    // edge right after the pulse was sampled.
    task automatic sof();
        repeat (2) @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    int exp_x [8] = '{403, 399, 397, 395, 395, 397, 399, 403};
    int exp_y [8] = '{430, 422, 413, 404, 396, 387, 378, 370};

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; buttonPress = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_x1", int'(x1_o[0]), 403);
        chk("rst_y1", int'(y1_o[0]), 430);
        chk("rst_idx", int'(idx_o[0]), 0);
        chk("rst_flags", int'({up_o[0], mov_o[0], kick_o[0]}), 0);

        // Frame pulse coinciding with reset release is ignored.
        resetN = 1'b1; startOfFrame = 1'b1; buttonPress = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0; buttonPress = 1'b0;
        chk("rel_sof_mov_d0", int'(mov_o[0]), 0);
        chk("rel_sof_mov_d1", int'(mov_o[1]), 0);
        $display("reset release with frame pulse: idx=%0d moving=%0d", idx_o[0], mov_o[0]);

        // Full swing up.
        buttonPress = 1'b1;
        sof();
        chk("swing1_mov", int'(mov_o[0]), 1);
        chk("swing1_up", int'(up_o[0]), 1);
        chk("swing1_idx", int'(idx_o[0]), 0);
        for (int s = 2; s <= 15; s++) begin
            sof();
            chk("swing_idx_d0", int'(idx_o[0]), (s - 1) / 2);
            if (s <= 8) begin
                chk("fast_idx_d1", int'(idx_o[1]), s - 1);
                chk("fast_x1_d1", int'(x1_o[1]), exp_x[s - 1]);
                chk("fast_y1_d1", int'(y1_o[1]), exp_y[s - 1]);
            end
            $display("rise sof %0d: idx0=%0d X1=%0d Y1=%0d kick=%0d", s, idx_o[0], x1_o[0], y1_o[0], kick_o[0]);
        end
        chk("top_x1", int'(x1_o[0]), 403);
        chk("top_y1", int'(y1_o[0]), 370);
        chk("top_kick", int'(kick_o[0]), 1);
        chk("top_up", int'(up_o[0]), 1);
        chk("top_mov", int'(mov_o[0]), 0);
        @(negedge clk);
        chk("kick_one_clk", int'(kick_o[0]), 0);

        // Release from HOLD.
        buttonPress = 1'b0;
        sof();
        chk("fall1_mov", int'(mov_o[0]), 1);
        chk("fall1_up", int'(up_o[0]), 0);
        chk("fall1_idx", int'(idx_o[0]), 7);
        for (int j = 1; j <= 14; j++) begin
            sof();
            if (j % 2 == 0) chk("fall_y1", int'(y1_o[0]), exp_y[7 - j / 2]);
            $display("fall sof %0d: idx0=%0d Y1=%0d", j, idx_o[0], y1_o[0]);
        end
        chk("fall_end_idx", int'(idx_o[0]), 0);
        chk("fall_end_up", int'(up_o[0]), 0);
        chk("fall_end_mov", int'(mov_o[0]), 0);

        // Reversal during RISING at idx 3, re-press during FALLING at idx 2.
        buttonPress = 1'b1;
        repeat (7) sof();
        chk("rev_rise_idx", int'(idx_o[0]), 3);
        buttonPress = 1'b0;
        sof();
        chk("rev_fall_idx", int'(idx_o[0]), 3);
        chk("rev_fall_mov", int'(mov_o[0]), 1);
        chk("rev_fall_up", int'(up_o[0]), 0);
        chk("rev_fall_kick", int'(kick_o[0]), 0);
        repeat (2) sof();
        chk("rev_fall_idx2", int'(idx_o[0]), 2);
        buttonPress = 1'b1;
        sof();
        chk("rev_rise2_idx", int'(idx_o[0]), 2);
        chk("rev_rise2_up", int'(up_o[0]), 1);
        for (int j = 1; j <= 10; j++) begin
            sof();
            chk("rev_kick", int'(kick_o[0]), int'(j == 10));
            $display("re-rise sof %0d: idx0=%0d kick=%0d", j, idx_o[0], kick_o[0]);
        end
        chk("rev_top_idx", int'(idx_o[0]), 7);
        buttonPress = 1'b0;
        repeat (16) sof();
        chk("rev_rest_idx", int'(idx_o[0]), 0);

        // Button pulse strictly between frames is invisible.
        repeat (2) @(negedge clk);
        buttonPress = 1'b1;
        repeat (100) @(negedge clk);
        buttonPress = 1'b0;
        sof();
        chk("glitch_mov", int'(mov_o[0]), 0);
        chk("glitch_x1", int'(x1_o[0]), 403);
        chk("glitch_y1", int'(y1_o[0]), 430);
        $display("between-frame button: idx=%0d X1=%0d Y1=%0d", idx_o[0], x1_o[0], y1_o[0]);

        // Reset mid-RISING at idx 4 snaps to rest immediately.
        buttonPress = 1'b1;
        repeat (9) sof();
        chk("pre_rst_idx", int'(idx_o[0]), 4);
        @(posedge clk);
        #2 resetN = 1'b0;
        #1;
        chk("mid_rst_x1", int'(x1_o[0]), 403);
        chk("mid_rst_y1", int'(y1_o[0]), 430);
        chk("mid_rst_idx", int'(idx_o[0]), 0);
        chk("mid_rst_flags", int'({up_o[0], mov_o[0], kick_o[0]}), 0);
        $display("async reset mid-swing: idx=%0d X1=%0d Y1=%0d", idx_o[0], x1_o[0], y1_o[0]);
        buttonPress = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/right_flipper_ctrl.md
Name: right_flipper_ctrl

Overview:
- Sequences the right flipper's swing. It converts the player's button into a frame-paced angle animation and drives the moving-edge coordinates (X1, Y1) that the flipper draw block consumes.
- Sits between the keyboard/button decoder and the flipper draw and collision logic. It also reports swing status to ball physics: an "up" flag and a one-clock kick pulse.
- Pivot is fixed at (XC, YC). The tip follows an 8-entry angle table, index 0 = rest (down) and index 7 = fully raised.

Parameters:
- XC, 455, pivot X (must match the draw block's fixed edge).
- YC, 400, pivot Y.
- STEP_FRAMES, 2, frames per angle step; legal range 1..15.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-clk pulse per VGA frame; the only event that advances the FSM.
- buttonPress  in  1  level; 1 = flipper key held; sampled only on startOfFrame.
- X1  out  11 signed  tip X = XC - DX[idx].
- Y1  out  11 signed  tip Y = YC + DY[idx].
- angleIdx  out  3  current table index.
- flipperUp  out  1  1 while state is RISING or HOLD.
- flipperMoving  out  1  1 while state is RISING or FALLING.
- kickPulse  out  1  one-clk pulse on the edge where idx reaches 7 from RISING.

Behaviour:
- Angle table (idx: DX, DY): 0:52,30; 1:56,22; 2:58,13; 3:60,4; 4:60,-4; 5:58,-13; 6:56,-22; 7:52,-30.
  - Tip length is about 60 px.
  - All arithmetic is 11-bit signed.
- Registers: state, idx (3b), frameCnt (4b), X1, Y1, kickPulse.
  - X1/Y1 are registered and load the table value of the next idx on the same edge that idx updates, so they are never one cycle stale.
  - flipperUp and flipperMoving decode the registered state.
- Reset (async, resetN=0): state=REST, idx=0, frameCnt=0, X1=XC-52 (403), Y1=YC+30 (430), kickPulse=0, flipperUp=0, flipperMoving=0. Reset mid-swing snaps the flipper to rest on the same cycle.
- No state, counter or output changes on clocks without startOfFrame, except that kickPulse clears to 0 one clk after being set.
- FSM, evaluated only when startOfFrame=1:
  - REST:
    - buttonPress=1 -> RISING, frameCnt=0; idx stays 0.
    - Otherwise stay.
  - RISING:
    - buttonPress=0 -> FALLING, frameCnt=0, no step this frame.
    - Else if frameCnt==STEP_FRAMES-1: idx+1, frameCnt=0. If the new idx==7 -> HOLD and kickPulse=1.
    - Else frameCnt+1.
  - HOLD (idx=7):
    - buttonPress=0 -> FALLING, frameCnt=0.
    - Otherwise stay.
  - FALLING:
    - buttonPress=1 -> RISING, frameCnt=0, no step this frame.
    - Else if frameCnt==STEP_FRAMES-1: idx-1, frameCnt=0. If the new idx==0 -> REST.
    - Else frameCnt+1.
- Timing: press to full raise takes 1 + 7*STEP_FRAMES startOfFrame pulses, measured from the first pulse that sees the button. Full fall takes 1 + 7*STEP_FRAMES pulses after release is sampled.
- Boundaries:
  - idx never wraps: saturates at 7 in RISING/HOLD and at 0 in FALLING/REST.
  - A reversal keeps the current idx and resets frameCnt.
  - STEP_FRAMES=1 steps on every frame.
  - A button toggle between frames is invisible; only the level at startOfFrame matters.
  - A startOfFrame asserted in the same cycle as resetN release is ignored.

Test Plan:
- Reset check: assert resetN=0 mid-RISING at idx=4 -> immediately X1=403, Y1=430, idx=0, state REST, all flags 0.
- Full swing (STEP_FRAMES=2): hold button; after 1 sof, RISING with flipperMoving=1; idx increments every 2nd sof thereafter.
  - On sof #15, idx=7, X1=403, Y1=370, kickPulse high exactly 1 clk, flipperUp=1, flipperMoving=0.
- Release from HOLD: drop button -> next sof FALLING. After 14 more sof, idx=0, state REST, flipperUp=0; Y1 walks 370,378,387,396,404,413,422,430.
- Reversal: release during RISING at idx=3 -> FALLING with idx held at 3, and no kickPulse.
  - Re-press during FALLING at idx=2 -> RISING from 2; kickPulse fires only on reaching 7.
- Sampling: pulse button high for 100 clks strictly between two startOfFrame pulses -> state stays REST, X1/Y1 unchanged.
- STEP_FRAMES=1 variant: hold button -> idx=7 after 8 sof; table values match at every index (X1 = 455 - DX, Y1 = 400 + DY).
